feature_quantizer_2b: RTL
=========================

# feature_quantizer_2b

Streaming front-end that turns raw per-feature samples into the packed 2-bit feature vector consumed by the evolved approximate classifier cores (six 2-bit operands `a`..`f`, one-bit decision). It accepts one IN_W-bit sample per cycle over a valid/ready stream and thresholds each sample into a 2-bit code. It assembles N_FEAT codes into one vector and presents that vector downstream through a registered valid/ready output. Collection of the next vector proceeds while the previous vector waits at the output.

## Interface
- N_FEAT, 6, features per vector; slot 0 maps to classifier operand `a`, slot 5 to `f`
- IN_W, 8, raw sample width, unsigned
- THR0 / THR1 / THR2, 64 / 128 / 192, default thresholds for every feature

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_data  in  IN_W  raw sample for the current slot
- s_last  in  1  marks final sample of a vector
- m_valid  out  1  vector valid
- m_ready  in  1  vector consumed when m_valid && m_ready
- m_feat  out  2*N_FEAT  packed codes, slot k at [2k+1:2k]
- m_err  out  1  vector framing error (s_last position mismatched)
- cfg_we, cfg_idx[$clog2(N_FEAT)], cfg_sel[1:0], cfg_data[IN_W]  in  threshold write port (present only with FQ_THR_PROG_EN)

## Operation
- Quantize: code = (x>=T0)+(x>=T1)+(x>=T2). Compares are unsigned, and the code is a count of thresholds met, so unsorted thresholds remain well defined. Result is 0..3.
- The assembly buffer holds slot index `idx` (0..N_FEAT-1), a code register, and an error bit. The buffer is in state FILL or FULL.
- FILL: s_ready=1. Each accepted beat writes its code to slot `idx`.
  - Beat that is neither idx==N_FEAT-1 nor s_last: `idx` increments.
  - Beat with idx==N_FEAT-1 or s_last: completes the vector.
  - Early s_last (idx<N_FEAT-1): the remaining slots are 0 and err=1.
  - Final slot without s_last: err=1. There is no resync; the next beat is slot 0 of the next vector.
- Completion: if the output register is empty, or is being consumed this cycle, the vector transfers to the output register at the same edge. The assembly buffer clears to FILL with idx=0. Otherwise the buffer goes to FULL.
- FULL: s_ready=0. The buffer transfers on the edge where the output is consumed, then returns to FILL.
- The output register holds m_feat and m_err stable while m_valid=1 and m_ready=0.

## Timing
- Reset values: m_valid=0, m_feat=0, m_err=0, s_ready=1, idx=0, buffer FILL. Thresholds reset to THR0..THR2.
- Latency: completing beat accepted at edge t; m_valid=1 from t+1.
- Throughput: one vector per N_FEAT cycles with m_ready held at 1. There are no bubbles.
- Simultaneous completion and output consume: the new vector is loaded and m_valid stays 1.
- With m_ready=0: one full vector buffered plus one in the output register. s_ready falls in the cycle after the second vector completes.
- rst_n asserted mid-vector: partial data is discarded and all outputs are forced to reset values asynchronously.

## Configuration
- FQ_THR_PROG_EN defined:
  - The cfg port exists and thresholds are per-feature registers.
  - A write with cfg_we=1 updates T[cfg_sel] of feature cfg_idx at the edge.
  - The new value applies to beats accepted in later cycles.
  - cfg_sel=3 and cfg_idx>=N_FEAT are ignored.
- FQ_THR_PROG_EN undefined: the cfg ports are absent and every feature uses constants THR0..THR2.

## Structure
- Package `feature_quantizer_pkg` holds:
  - N_FEAT, IN_W, and the THR* defaults
  - the assembly state enum {FILL, FULL}
  - function `quantize2b(x, t0, t1, t2)`
- Sub-module `fq_thresh_cmp`: three comparators plus the adder, producing the 2-bit code. There is a single instance, fed by the thresholds of slot `idx`.

## Test plan
- Defaults; beats 0,63,64,128,191,255 with s_last on the 6th -> m_feat=0xE90, m_err=0, m_valid the cycle after the 6th beat.
- Beats 200,200,200 with s_last on the 3rd -> m_feat=0x03F, m_err=1; the next 6-beat vector is framed correctly.
- Six beats of 255 with no s_last -> m_feat=0xFFF, m_err=1; the 7th beat lands in slot 0 of the next vector.
- m_ready=0, 12 beats streamed -> s_ready=0 after the 12th; first vector held stable. Raise m_ready -> vectors pop in order on consecutive cycles; s_ready=1 again.
- Three beats accepted, then rst_n pulsed low -> m_valid=0, m_feat=0 immediately. A fresh 6-beat vector is then assembled from slot 0.
- FQ_THR_PROG_EN: write feature 0, sel 0, value 10; then beats 10,0,0,0,0,0 with s_last -> m_feat=0x001.

Source files
------------

// File: rtl/feature_quantizer_pkg.sv
// Shared parameters, assembly state type and the 2-bit threshold quantizer
// used by feature_quantizer_2b.
package feature_quantizer_pkg;

  localparam int N_FEAT = 6;
  localparam int IN_W   = 8;
  localparam int IDX_W  = $clog2(N_FEAT);
  localparam int FEAT_W = 2 * N_FEAT;

  localparam logic [IN_W-1:0] THR0 = 8'd64;
  localparam logic [IN_W-1:0] THR1 = 8'd128;
  localparam logic [IN_W-1:0] THR2 = 8'd192;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } asm_state_t;

  // Count of thresholds met, so unsorted thresholds still give a defined code.
  function automatic logic [1:0] quantize2b(
    input logic [IN_W-1:0] x,
    input logic [IN_W-1:0] t0,
    input logic [IN_W-1:0] t1,
    input logic [IN_W-1:0] t2
  );
    logic [1:0] code;
    code = {1'b0, (x >= t0)} + {1'b0, (x >= t1)} + {1'b0, (x >= t2)};
    return code;
  endfunction

endpackage

// File: rtl/feature_quantizer_2b_thresh_cmp.sv
// Three unsigned comparators and their sum: maps one raw sample to a 2-bit
// code against the thresholds of the slot being filled.
module fq_thresh_cmp
  import feature_quantizer_pkg::*;
(
  input  logic [IN_W-1:0] x,
  input  logic [IN_W-1:0] t0,
  input  logic [IN_W-1:0] t1,
  input  logic [IN_W-1:0] t2,
  output logic [1:0]      code
);

  assign code = quantize2b(x, t0, t1, t2);

endmodule

// File: rtl/feature_quantizer_2b.sv
// Streaming 2-bit feature quantizer: assembles N_FEAT codes into one packed
// vector behind a registered valid/ready output. Optional macro
// FQ_THR_PROG_EN adds a per-feature programmable threshold port.
module feature_quantizer_2b
  import feature_quantizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FEAT_W-1:0] m_feat,
  output logic              m_err
`ifdef FQ_THR_PROG_EN
  ,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_sel,
  input  logic [IN_W-1:0]   cfg_data
`endif
);

  asm_state_t        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [FEAT_W-1:0] buf_r;
  logic              buf_err_r;
  logic              out_valid_r;
  logic [FEAT_W-1:0] out_feat_r;
  logic              out_err_r;

  logic [IN_W-1:0]   t0_s;
  logic [IN_W-1:0]   t1_s;
  logic [IN_W-1:0]   t2_s;
  logic [1:0]        code_s;
  logic              accept_s;
  logic              last_slot_s;
  logic              complete_s;
  logic              out_free_s;
  logic [FEAT_W-1:0] vec_s;
  logic              vec_err_s;

`ifdef FQ_THR_PROG_EN
  logic [IN_W-1:0] thr_r [N_FEAT][3];
  logic            cfg_hit_s;

  assign cfg_hit_s = cfg_we && (cfg_sel != 2'd3) && (cfg_idx < IDX_W'(N_FEAT));

  // Per-feature threshold registers, written through the cfg port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FEAT; k++) begin
        thr_r[k][0] <= THR0;
        thr_r[k][1] <= THR1;
        thr_r[k][2] <= THR2;
      end
    end else if (cfg_hit_s) begin
      thr_r[cfg_idx][cfg_sel] <= cfg_data;
    end
  end

  // Thresholds of the slot currently being filled.
  always_comb begin
    t0_s = thr_r[idx_r][0];
    t1_s = thr_r[idx_r][1];
    t2_s = thr_r[idx_r][2];
  end
`else
  assign t0_s = THR0;
  assign t1_s = THR1;
  assign t2_s = THR2;
`endif

  fq_thresh_cmp u_cmp (
    .x    (s_data),
    .t0   (t0_s),
    .t1   (t1_s),
    .t2   (t2_s),
    .code (code_s)
  );

  assign s_ready     = (state_r == FILL);
  assign accept_s    = s_valid && s_ready;
  assign last_slot_s = (idx_r == IDX_W'(N_FEAT - 1));
  assign complete_s  = accept_s && (last_slot_s || s_last);
  assign out_free_s  = !out_valid_r || m_ready;

  // Buffer contents after this beat; slots beyond idx read as zero on early s_last.
  always_comb begin
    vec_s = {FEAT_W{1'b0}};
    for (int k = 0; k < N_FEAT; k++) begin
      if (IDX_W'(k) < idx_r) begin
        vec_s[2*k +: 2] = buf_r[2*k +: 2];
      end else if (IDX_W'(k) == idx_r) begin
        vec_s[2*k +: 2] = code_s;
      end else begin
        vec_s[2*k +: 2] = 2'b00;
      end
    end
    vec_err_s = last_slot_s ^ s_last;
  end

  // Assembly buffer state machine and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      idx_r       <= {IDX_W{1'b0}};
      buf_r       <= {FEAT_W{1'b0}};
      buf_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_feat_r  <= {FEAT_W{1'b0}};
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (complete_s) begin
            idx_r <= {IDX_W{1'b0}};
            if (out_free_s) begin
              out_valid_r <= 1'b1;
              out_feat_r  <= vec_s;
              out_err_r   <= vec_err_s;
              buf_r       <= {FEAT_W{1'b0}};
              buf_err_r   <= 1'b0;
            end else begin
              buf_r     <= vec_s;
              buf_err_r <= vec_err_s;
              state_r   <= FULL;
            end
          end else begin
            if (accept_s) begin
              buf_r <= vec_s;
              idx_r <= idx_r + IDX_W'(1);
            end
            if (m_ready) begin
              out_valid_r <= 1'b0;
            end
          end
        end
        FULL: begin
          // Output is necessarily occupied here; hand over on consume.
          if (m_ready) begin
            out_valid_r <= 1'b1;
            out_feat_r  <= buf_r;
            out_err_r   <= buf_err_r;
            buf_r       <= {FEAT_W{1'b0}};
            buf_err_r   <= 1'b0;
            state_r     <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
          idx_r   <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign m_valid = out_valid_r;
  assign m_feat  = out_feat_r;
  assign m_err   = out_err_r;

endmodule
